// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Brief    : Shared mode/colour encodings and default tick periods for the
//            LED pattern driver.
// Revision : 1.0
// ============================================================================
package led_pkg;

  localparam logic MODE_SR = 1'b0;
  localparam logic MODE_FS = 1'b1;

  localparam logic [2:0] COL_RED   = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b100;

  localparam int unsigned DEF_LIMIT_0 = 32'h0080_0000;
  localparam int unsigned DEF_LIMIT_1 = 32'h0100_0000;
  localparam int unsigned DEF_LIMIT_2 = 32'h0200_0000;
  localparam int unsigned DEF_LIMIT_3 = 32'h0400_0000;

  function automatic logic is_one_hot(input logic [2:0] col);
    return (col == COL_RED) || (col == COL_GREEN) || (col == COL_BLUE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_if
// Brief    : Control inputs and LED bank outputs of the pattern driver.
// Revision : 1.0
// ============================================================================
interface led_pattern_if #(
  parameter int NB_LEDS = 4
);
  logic               i_enable;
  logic               i_mode;
  logic [2:0]         i_sel_col;
  logic               i_dir;
  logic [1:0]         i_speed;
  logic [NB_LEDS-1:0] o_led_r;
  logic [NB_LEDS-1:0] o_led_g;
  logic [NB_LEDS-1:0] o_led_b;
  logic               o_tick;

  modport master (
    output i_enable, i_mode, i_sel_col, i_dir, i_speed,
    input  o_led_r, o_led_g, o_led_b, o_tick
  );

  modport slave (
    input  i_enable, i_mode, i_sel_col, i_dir, i_speed,
    output o_led_r, o_led_g, o_led_b, o_tick
  );
endinterface
`default_nettype wire

// File: rtl/led_pattern_driver_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Prescaler producing a step pulse every LIMIT_[i_speed] cycles.
// Revision : 1.0
// ============================================================================
module tick_gen
  import led_pkg::*;
#(
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_0    = DEF_LIMIT_0,
  parameter int unsigned LIMIT_1    = DEF_LIMIT_1,
  parameter int unsigned LIMIT_2    = DEF_LIMIT_2,
  parameter int unsigned LIMIT_3    = DEF_LIMIT_3
) (
  input  wire logic       clock,
  input  wire logic       i_reset,
  input  wire logic       i_enable,
  input  wire logic       i_clear,
  input  wire logic [1:0] i_speed,
  output logic            o_tick_comb,
  output logic            o_tick
);

  logic [NB_COUNTER-1:0] r_counter;
  logic [NB_COUNTER-1:0] w_limit_m1;
  logic                  r_tick;

  always_comb begin
    w_limit_m1 = NB_COUNTER'(LIMIT_0 - 1);
    case (i_speed)
      2'd0:    w_limit_m1 = NB_COUNTER'(LIMIT_0 - 1);
      2'd1:    w_limit_m1 = NB_COUNTER'(LIMIT_1 - 1);
      2'd2:    w_limit_m1 = NB_COUNTER'(LIMIT_2 - 1);
      default: w_limit_m1 = NB_COUNTER'(LIMIT_3 - 1);
    endcase
  end

  // >= so that switching to a shorter period mid-count fires at once
  assign o_tick_comb = i_enable & ~i_clear & (r_counter >= w_limit_m1);
  assign o_tick      = r_tick;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_counter <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= o_tick_comb;
      if (!i_enable || i_clear || o_tick_comb)
        r_counter <= '0;
      else
        r_counter <= r_counter + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_driver
// Brief    : Rotating-LED / flash pattern generator driving RGB LED banks.
// Revision : 1.0
// ============================================================================
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int          NB_LEDS    = 4,
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_0    = DEF_LIMIT_0,
  parameter int unsigned LIMIT_1    = DEF_LIMIT_1,
  parameter int unsigned LIMIT_2    = DEF_LIMIT_2,
  parameter int unsigned LIMIT_3    = DEF_LIMIT_3
) (
  input  wire logic    clock,
  input  wire logic    i_reset,
  led_pattern_if.slave bus
);

  localparam logic [NB_LEDS-1:0] c_sr_init = {{(NB_LEDS-1){1'b0}}, 1'b1};

  logic               r_mode;
  logic [2:0]         r_col;
  logic [NB_LEDS-1:0] r_sr;
  logic [NB_LEDS-1:0] r_fs;
  logic [NB_LEDS-1:0] r_led_r;
  logic [NB_LEDS-1:0] r_led_g;
  logic [NB_LEDS-1:0] r_led_b;
  logic [NB_LEDS-1:0] w_sr_next;
  logic [NB_LEDS-1:0] w_fs_next;
  logic [NB_LEDS-1:0] w_pattern;
  logic               w_mode_chg;
  logic               w_tick;

  assign w_mode_chg = (r_mode != bus.i_mode);

  tick_gen #(
    .NB_COUNTER (NB_COUNTER),
    .LIMIT_0    (LIMIT_0),
    .LIMIT_1    (LIMIT_1),
    .LIMIT_2    (LIMIT_2),
    .LIMIT_3    (LIMIT_3)
  ) u_tick_gen (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (bus.i_enable),
    .i_clear     (w_mode_chg),
    .i_speed     (bus.i_speed),
    .o_tick_comb (w_tick),
    .o_tick      (bus.o_tick)
  );

  always_comb begin
    w_sr_next = r_sr;
    w_fs_next = r_fs;
    if (w_mode_chg) begin
      w_sr_next = c_sr_init;
      w_fs_next = '0;
    end else if (w_tick) begin
      if (r_mode == MODE_FS)
        w_fs_next = ~r_fs;
      else if (bus.i_dir)
        w_sr_next = {r_sr[0], r_sr[NB_LEDS-1:1]};
      else
        w_sr_next = {r_sr[NB_LEDS-2:0], r_sr[NB_LEDS-1]};
    end
  end

  // Banks are fed from next-state so the new step lands together with o_tick
  assign w_pattern = (bus.i_mode == MODE_FS) ? w_fs_next : w_sr_next;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mode  <= MODE_SR;
      r_col   <= COL_RED;
      r_sr    <= c_sr_init;
      r_fs    <= '0;
      r_led_r <= '0;
      r_led_g <= '0;
      r_led_b <= '0;
    end else begin
      r_mode  <= bus.i_mode;
      r_sr    <= w_sr_next;
      r_fs    <= w_fs_next;
      if (is_one_hot(bus.i_sel_col))
        r_col <= bus.i_sel_col;
      r_led_r <= w_pattern & {NB_LEDS{r_col[0]}};
      r_led_g <= w_pattern & {NB_LEDS{r_col[1]}};
      r_led_b <= w_pattern & {NB_LEDS{r_col[2]}};
    end
  end

  assign bus.o_led_r = r_led_r;
  assign bus.o_led_g = r_led_g;
  assign bus.o_led_b = r_led_b;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_driver
// Brief    : Scoreboard bench for led_pattern_driver with short tick periods.
// Revision : 1.0
// ============================================================================
module tb_led_pattern_driver;

  logic clock   = 1'b0;
  logic i_reset = 1'b0;

  int checks   = 0;
  int failures = 0;

  // expected {b, g, r} banks, pushed with stimulus, popped on each output event
  logic [11:0] exp_q[$];

  led_pattern_if #(.NB_LEDS(4)) bus ();

  led_pattern_driver #(
    .NB_LEDS    (4),
    .NB_COUNTER (32),
    .LIMIT_0    (4),
    .LIMIT_1    (8),
    .LIMIT_2    (16),
    .LIMIT_3    (32)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] leds();
    return {bus.o_led_b, bus.o_led_g, bus.o_led_r};
  endfunction

  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cyc++;
      if (bus.o_tick === 1'b1) return;
    end
    cyc = -1;
  endtask

  // Waits for n ticks, checking the interval and popping one expectation per tick
  task automatic run_ticks(input string name, input int n, input int first_gap, input int gap);
    int          cyc;
    logic [11:0] exp;
    for (int k = 0; k < n; k++) begin
      wait_tick(64, cyc);
      checks++;
      if (cyc !== ((k == 0) ? first_gap : gap)) begin
        failures++;
        $display("FAIL %s_period[%0d]: got %0d cycles, expected %0d", name, k, cyc,
                 (k == 0) ? first_gap : gap);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_pattern[%0d]: scoreboard empty, got %h", name, k, leds());
      end else begin
        exp = exp_q.pop_front();
        if (leds() !== exp) begin
          failures++;
          $display("FAIL %s_pattern[%0d]: got %h, expected %h", name, k, leds(), exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.i_enable  = 1'b1;
    bus.i_mode    = 1'b0;
    bus.i_sel_col = 3'b001;
    bus.i_dir     = 1'b0;
    bus.i_speed   = 2'd0;
    i_reset       = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (leds() !== 12'h000) begin
      failures++;
      $display("FAIL reset_leds: got %h, expected 000", leds());
    end
    checks++;
    if (bus.o_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick: got %b, expected 0", bus.o_tick);
    end
    i_reset = 1'b1;
    exp_q.push_back(12'h001);
    @(negedge clock);
    checks++;
    if (leds() !== exp_q[0]) begin
      failures++;
      $display("FAIL first_output: got %h, expected %h", leds(), exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_shift();
    exp_q.push_back(12'h002);
    exp_q.push_back(12'h004);
    exp_q.push_back(12'h008);
    exp_q.push_back(12'h001);
    run_ticks("shift_left", 4, 3, 4);
  endtask

  task automatic test_dir();
    bus.i_dir = 1'b1;
    exp_q.push_back(12'h008);
    exp_q.push_back(12'h004);
    run_ticks("shift_right", 2, 4, 4);
  endtask

  task automatic test_mode();
    bus.i_mode = 1'b1;
    @(negedge clock);
    checks++;
    if (leds() !== 12'h000 || bus.o_tick !== 1'b0) begin
      failures++;
      $display("FAIL mode_switch: got leds %h tick %b, expected 000 0", leds(), bus.o_tick);
    end
    exp_q.push_back(12'h00F);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h00F);
    run_ticks("flash", 3, 4, 4);
  endtask

  task automatic test_colour();
    logic [11:0] exp;
    bus.i_enable  = 1'b0;
    bus.i_sel_col = 3'b010;
    exp_q.push_back(12'h00F);
    exp_q.push_back(12'h0F0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      exp = exp_q.pop_front();
      checks++;
      if (leds() !== exp) begin
        failures++;
        $display("FAIL colour_green[%0d]: got %h, expected %h", k, leds(), exp);
      end
    end
    bus.i_sel_col = 3'b000;
    exp_q.push_back(12'h0F0);
    repeat (2) @(negedge clock);
    exp = exp_q.pop_front();
    checks++;
    if (leds() !== exp) begin
      failures++;
      $display("FAIL colour_zero: got %h, expected %h", leds(), exp);
    end
    bus.i_sel_col = 3'b011;
    exp_q.push_back(12'h0F0);
    repeat (2) @(negedge clock);
    exp = exp_q.pop_front();
    checks++;
    if (leds() !== exp) begin
      failures++;
      $display("FAIL colour_multi: got %h, expected %h", leds(), exp);
    end
  endtask

  task automatic test_speed();
    int          early;
    int          bad;
    logic [11:0] exp;
    bus.i_sel_col = 3'b001;
    bus.i_speed   = 2'd3;
    repeat (2) @(negedge clock);
    bus.i_enable = 1'b1;
    early = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.o_tick === 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL slow_no_tick: got %0d ticks, expected 0", early);
    end
    bus.i_speed = 2'd0;
    exp_q.push_back(12'h000);
    @(negedge clock);
    exp = exp_q.pop_front();
    checks++;
    if (bus.o_tick !== 1'b1 || leds() !== exp) begin
      failures++;
      $display("FAIL speed_drop: got tick %b leds %h, expected 1 %h", bus.o_tick, leds(), exp);
    end
    exp_q.push_back(12'h00F);
    exp_q.push_back(12'h000);
    run_ticks("fast", 2, 4, 4);

    bus.i_enable = 1'b0;
    early = 0;
    bad   = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.o_tick === 1'b1) early++;
      if (leds() !== 12'h000) bad++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL disabled_tick: got %0d ticks, expected 0", early);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL disabled_hold: got %0d changed cycles, expected 0", bad);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    bus.i_enable = 1'b1;
    exp_q.push_back(12'h00F);
    run_ticks("pre_reset", 1, 4, 4);
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (leds() !== 12'h000 || bus.o_tick !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got leds %h tick %b, expected 000 0", leds(), bus.o_tick);
    end
    bus.i_mode = 1'b0;
    @(negedge clock);
    checks++;
    if (leds() !== 12'h000) begin
      failures++;
      $display("FAIL reset_held: got %h, expected 000", leds());
    end
    i_reset = 1'b1;
    exp_q.push_back(12'h001);
    @(negedge clock);
    exp = exp_q.pop_front();
    checks++;
    if (leds() !== exp) begin
      failures++;
      $display("FAIL post_reset: got %h, expected %h", leds(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_dir();
    test_mode();
    test_colour();
    test_speed();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_driver.md
# led_pattern_driver

Display-side consumer of the button front end. It takes the debounced mode bit and the one-hot colour select produced by the edge-detect logic, generates a shift-register (rotating single LED) or flash (all LEDs toggling) pattern at a selectable rate, and drives the RGB LED banks of the board. It sits between the button/selection logic and the top-level LED pins.

## Interface
Parameters:
- NB_LEDS, 4, LEDs per colour bank
- NB_COUNTER, 32, prescaler counter width
- LIMIT_0, 2**23, tick period in cycles for i_speed = 0
- LIMIT_1, 2**24, tick period for i_speed = 1
- LIMIT_2, 2**25, tick period for i_speed = 2
- LIMIT_3, 2**26, tick period for i_speed = 3

Ports:
- clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  1 = pattern advances, 0 = pattern frozen
- i_mode  in  1  0 = shift-register mode, 1 = flash mode
- i_sel_col  in  3  one-hot colour select: bit0 red, bit1 green, bit2 blue
- i_dir  in  1  shift direction: 0 = towards MSB, 1 = towards LSB
- i_speed  in  2  selects LIMIT_0..LIMIT_3
- o_led_r  out  NB_LEDS  red bank
- o_led_g  out  NB_LEDS  green bank
- o_led_b  out  NB_LEDS  blue bank
- o_tick  out  1  one-cycle pulse on each pattern step

## Operation
- Reset (i_reset low, asynchronous): counter = 0, sr = 0…01, fs = 0…0, colour register = 3'b001, mode register = 0, all outputs 0.
- Prescaler: limit = LIMIT_[i_speed]. While i_enable = 1, counter increments; when counter >= limit-1, tick asserts for that cycle and counter wraps to 0. The `>=` comparison means that a speed change to a smaller limit mid-count forces a tick on the next compare and never overruns.
- While i_enable = 0: counter held at 0, no tick, sr/fs frozen, outputs keep the last pattern.
- Shift mode: on tick, sr rotates left by one if i_dir = 0 and right if i_dir = 1. Rotation is circular: MSB→LSB and LSB→MSB. Exactly one bit is always set.
- Flash mode: on tick, fs <= ~fs.
- Mode change: i_mode is registered each cycle. When the registered value differs from i_mode, sr is reloaded to 0…01, fs is cleared, and the counter is cleared. This takes priority over a tick in the same cycle.
- Colour: the colour register loads i_sel_col only when it is exactly one-hot (001, 010, 100). Any other value (000, multi-hot) leaves it unchanged.
- Output: pattern = mode ? fs : sr. Each bank = pattern gated by its colour bit, so two banks are never lit at once.

## Timing
- Outputs and o_tick are registered, giving one cycle of latency from internal state or input change to the pins.
- First non-zero output: o_led_r = 0…01 on the first rising edge after i_reset deasserts.
- Step period: exactly LIMIT_[i_speed] cycles between o_tick pulses while enabled and unchanged.
- Pattern on outputs updates in the same cycle o_tick is high.
- Colour change: visible 2 cycles after i_sel_col changes (input capture plus output register).
- Reset asserted mid-operation returns every output to 0 immediately, without waiting for a clock edge.

## Structure
- Shared package led_pkg: MODE_SR = 1'b0, MODE_FS = 1'b1; COL_RED = 3'b001, COL_GREEN = 3'b010, COL_BLUE = 3'b100; default LIMIT_* values.
- One sub-module, tick_gen: the counter, the limit mux, the compare, and the clear input. Its outputs are tick and a registered o_tick.
- The pattern registers, colour register and output gating stay in led_pattern_driver.

## Test plan
All scenarios use NB_LEDS = 4 and LIMIT_0..3 = 4, 8, 16, 32.
- Reset release, i_enable = 1, i_mode = 0, i_speed = 0, i_dir = 0 → o_led_r sequence 0001, 0010, 0100, 1000, 0001 with o_tick every 4 cycles; o_led_g = o_led_b = 0.
- i_dir = 1 from state 0001 → next tick gives 1000, then 0100 (wrap-around).
- i_mode 0→1 with sr = 0100 → outputs 0000 next, then 1111/0000 alternating every 4 cycles; the counter restarts, so the first toggle comes 4 cycles after the switch.
- i_sel_col = 010, then 000, then 011 → pattern moves to o_led_g and stays on green for both 000 and 011; o_led_r = 0.
- i_speed 3→0 when counter = 20 → tick on the next cycle, then every 4 cycles; i_enable = 0 → no ticks, pattern held for 100 cycles.
- i_reset pulsed low between clock edges while flash output = 1111 → all outputs 0 immediately; after release, o_led_r = 0001.
